// File: rtl/uart_core_cfg.sv
// rtl/uart_core_cfg.sv - configurable-format UART core with baud divisor, TX/RX FIFOs and RX error tagging
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   din,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL_LVL) || do_pop);
  assign dout    = mem[rptr];
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

module uart_core_cfg #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int DIV_W    = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wren,
  input  logic [7:0]                      wr_data,
  input  logic                            rden,
  output logic [7:0]                      rd_data,
  output logic [1:0]                      rd_err,
  input  logic                            tx_en,
  input  logic                            rx_en,
  input  logic                            loopback,
  input  logic [1:0]                      data_len,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            stop2,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic                            ovr_clr,
  output logic [5:0]                      status,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
  input  logic                            rx,
  output logic                            tx
);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

  logic [DIV_W-1:0] baud_cnt;
  logic             tick;
  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     baud_cnt <= '0;
    else if (tick) baud_cnt <= baud_div;
    else           baud_cnt <= baud_cnt - 1'b1;
  end

  // ---------------- TX ----------------
  tx_state_t  tx_state, tx_state_d;
  logic [7:0] tx_head, tx_sh, tx_mask;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bit, tx_nb;
  logic       tx_pen, tx_pbit, tx_s2, tx_second, tx_pop, tx_full, tx_empty, tx_bit_end;

  uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(wren), .pop(tx_pop), .din(wr_data),
    .dout(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  assign tx_bit_end = tick && (tx_tcnt == 4'd15);
  assign tx_mask    = 8'hFF >> (2'd3 - data_len);

  always_comb begin
    tx_state_d = tx_state;
    tx_pop     = 1'b0;
    case (tx_state)
      T_IDLE:  if (tick && tx_en && !tx_empty) begin
                 tx_pop     = 1'b1;
                 tx_state_d = T_START;
               end
      T_START: if (tx_bit_end) tx_state_d = T_DATA;
      T_DATA:  if (tx_bit_end && (tx_bit == tx_nb)) tx_state_d = tx_pen ? T_PAR : T_STOP;
      T_PAR:   if (tx_bit_end) tx_state_d = T_STOP;
      T_STOP:  if (tx_bit_end && (!tx_s2 || tx_second)) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Line level decoded from state so reset drives it high without waiting for a clock
  always_comb begin
    case (tx_state)
      T_START: tx = 1'b0;
      T_DATA:  tx = tx_sh[0];
      T_PAR:   tx = tx_pbit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_state <= T_IDLE;
    else       tx_state <= tx_state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sh <= '0; tx_tcnt <= '0; tx_bit <= '0; tx_nb <= '0;
      tx_pen <= 1'b0; tx_pbit <= 1'b0; tx_s2 <= 1'b0; tx_second <= 1'b0;
    end else begin
      if (tx_state != tx_state_d) tx_tcnt <= '0;
      else if (tick)              tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_pop) begin
        tx_sh     <= tx_head;
        tx_nb     <= 3'd4 + {1'b0, data_len};
        tx_pen    <= parity_en;
        tx_pbit   <= ^(tx_head & tx_mask) ^ parity_odd;
        tx_s2     <= stop2;
        tx_bit    <= '0;
        tx_second <= 1'b0;
      end
      if (tx_state == T_DATA && tx_bit_end) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
      if (tx_state == T_STOP && tx_bit_end) tx_second <= 1'b1;
    end
  end

  // ---------------- RX ----------------
  rx_state_t  rx_state, rx_state_d;
  logic       rx_s1, rx_s2, rx_in, rx_samp, rx_push, rx_full, rx_empty;
  logic       rx_pen, rx_podd, rx_pbit, rx_par_err, overrun;
  logic [1:0] rx_len;
  logic [2:0] rx_bit;
  logic [3:0] rx_tcnt;
  logic [7:0] rx_sh, rx_word;
  logic [9:0] rx_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_in      = loopback ? tx : rx_s2;
  assign rx_samp    = tick && (rx_tcnt == 4'd15);
  assign rx_word    = rx_sh >> (2'd3 - rx_len);
  assign rx_par_err = rx_pen & (^rx_word ^ rx_podd ^ rx_pbit);

  always_comb begin
    rx_state_d = rx_state;
    rx_push    = 1'b0;
    case (rx_state)
      R_IDLE:  if (rx_en && !rx_in) rx_state_d = R_START;
      R_START: if (tick && (rx_tcnt == 4'd7)) rx_state_d = rx_in ? R_IDLE : R_DATA;
      R_DATA:  if (rx_samp && (rx_bit == 3'd4 + {1'b0, rx_len})) rx_state_d = rx_pen ? R_PAR : R_STOP;
      R_PAR:   if (rx_samp) rx_state_d = R_STOP;
      R_STOP:  if (rx_samp) begin
                 rx_push    = 1'b1;
                 rx_state_d = rx_in ? R_IDLE : R_WAIT;
               end
      R_WAIT:  if (rx_in) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= R_IDLE;
    else       rx_state <= rx_state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_len <= '0; rx_pen <= 1'b0; rx_podd <= 1'b0; rx_pbit <= 1'b0;
      rx_bit <= '0; rx_tcnt <= '0; rx_sh <= '0;
    end else begin
      if (rx_state != rx_state_d) rx_tcnt <= '0;
      else if (tick)              rx_tcnt <= rx_tcnt + 4'd1;
      if (rx_state == R_IDLE && rx_state_d == R_START) begin
        rx_len  <= data_len;
        rx_pen  <= parity_en;
        rx_podd <= parity_odd;
        rx_bit  <= '0;
      end
      // Bits enter at the MSB; rx_word right-aligns them once the frame is complete
      if (rx_state == R_DATA && rx_samp) begin
        rx_sh  <= {rx_in, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_state == R_PAR && rx_samp) rx_pbit <= rx_in;
    end
  end

  uart_fifo #(.DEPTH(RX_DEPTH), .W(10)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .pop(rden),
    .din({~rx_in, rx_par_err, rx_word}),
    .dout(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
      rd_err  <= '0;
      overrun <= 1'b0;
    end else begin
      if (rden && !rx_empty) {rd_err, rd_data} <= rx_head;
      if (rx_push && rx_full && !rden) overrun <= 1'b1;
      else if (ovr_clr)                overrun <= 1'b0;
    end
  end

  assign status = {overrun, rx_state != R_IDLE, tx_state != T_IDLE, rx_full, rx_empty, tx_full};
endmodule

// File: tb/tb_uart_core_cfg.sv
// tb/tb_uart_core_cfg.sv - self-checking bench for uart_core_cfg
module tb_uart_core_cfg;
  logic        clk = 0, rstn = 0, wren = 0, rden = 0, tx_en = 0, rx_en = 0, loopback = 0;
  logic [7:0]  wr_data = 0, rd_data;
  logic [1:0]  rd_err, data_len = 2'd3;
  logic        parity_en = 0, parity_odd = 0, stop2 = 0, ovr_clr = 0, rx = 1, tx;
  logic [15:0] baud_div = 16'd3;
  logic [5:0]  status;
  logic [2:0]  tx_level, rx_level;

  int errors = 0, checks = 0;

  uart_core_cfg #(.TX_DEPTH(4), .RX_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rstn(rstn), .wren(wren), .wr_data(wr_data), .rden(rden),
    .rd_data(rd_data), .rd_err(rd_err), .tx_en(tx_en), .rx_en(rx_en),
    .loopback(loopback), .data_len(data_len), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .baud_div(baud_div), .ovr_clr(ovr_clr),
    .status(status), .tx_level(tx_level), .rx_level(rx_level), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] len;
    logic       pen, podd, s2;
    logic [7:0] wdata, exp_data;
    logic [1:0] exp_err;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_fmt(input logic [1:0] len, input logic pen, input logic podd, input logic s2);
    data_len = len; parity_en = pen; parity_odd = podd; stop2 = s2;
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bit(s)
  function automatic int frame_bits(input logic [1:0] len, input logic pen, input logic podd,
                                    input logic s2, input logic [7:0] b, input logic flip,
                                    input logic zs, output logic [15:0] bits);
    int n = 0;
    logic p = podd;
    bits = '1;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 5 + int'(len); i++) begin
      bits[n] = b[i]; p ^= b[i]; n++;
    end
    if (pen) begin bits[n] = p ^ flip; n++; end
    bits[n] = ~zs; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  function automatic logic [9:0] expect_word(input logic [1:0] len, input logic pen,
                                             input logic [7:0] b, input logic flip, input logic zs);
    logic [7:0] d = '0;
    for (int i = 0; i < 5 + int'(len); i++) d[i] = b[i];
    return {zs, pen & flip, d};
  endfunction

  task automatic send_frame(input logic [1:0] len, input logic pen, input logic podd, input logic s2,
                            input logic [7:0] b, input logic flip, input logic zs, input int bitclk);
    logic [15:0] bits;
    int n;
    set_fmt(len, pen, podd, s2);
    n = frame_bits(len, pen, podd, s2, b, flip, zs, bits);
    for (int i = 0; i < n; i++) begin rx = bits[i]; step(bitclk); end
    rx = 1'b1;
    step(2 * bitclk);
  endtask

  task automatic wait_level(input int want, input int limit);
    int t = 0;
    while (int'(rx_level) != want && t < limit) begin step(1); t++; end
    check("rx_level_wait", 32'(rx_level), 32'(want));
  endtask

  task automatic read_rx(output logic [7:0] d, output logic [1:0] e);
    rden = 1; step(1); rden = 0;
    d = rd_data; e = rd_err;
  endtask

  task automatic wait_tx_low(input int limit);
    int t = 0;
    while (tx !== 1'b0 && t < limit) begin step(1); t++; end
    check("tx_start", 32'(tx), 32'h0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  e;
    logic [15:0] bits;
    logic [9:0]  w;
    int          n, dv, bitclk;
    logic [1:0]  len;
    logic        pen, podd, s2, flip, zs;
    logic [7:0]  b;

    vecs[0] = '{len: 2'd3, pen: 1'b0, podd: 1'b0, s2: 1'b0, wdata: 8'hA5, exp_data: 8'hA5, exp_err: 2'b00};
    vecs[1] = '{len: 2'd2, pen: 1'b1, podd: 1'b0, s2: 1'b1, wdata: 8'h53, exp_data: 8'h53, exp_err: 2'b00};
    vecs[2] = '{len: 2'd0, pen: 1'b1, podd: 1'b1, s2: 1'b0, wdata: 8'hFF, exp_data: 8'h1F, exp_err: 2'b00};
    vecs[3] = '{len: 2'd1, pen: 1'b0, podd: 1'b0, s2: 1'b1, wdata: 8'hC6, exp_data: 8'h06, exp_err: 2'b00};

    step(3);
    rstn = 1;
    step(2);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_status", 32'(status), 32'h02);
    check("reset_tx_level", 32'(tx_level), 32'h0);
    check("reset_rx_level", 32'(rx_level), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);

    // Loopback table: waveform at each bit centre, then the received byte
    loopback = 1; tx_en = 1; rx_en = 1; baud_div = 16'd3;
    for (int v = 0; v < 4; v++) begin
      set_fmt(vecs[v].len, vecs[v].pen, vecs[v].podd, vecs[v].s2);
      wr_data = vecs[v].wdata; wren = 1; step(1); wren = 0;
      wait_tx_low(400);
      n = frame_bits(vecs[v].len, vecs[v].pen, vecs[v].podd, vecs[v].s2, vecs[v].wdata, 1'b0, 1'b0, bits);
      step(32);
      check("tx_bit0", 32'(tx), 32'(bits[0]));
      for (int k = 1; k < n; k++) begin
        step(64);
        check($sformatf("tx_v%0d_bit%0d", v, k), 32'(tx), 32'(bits[k]));
      end
      wait_level(1, 200);
      read_rx(d, e);
      check($sformatf("lb_data_v%0d", v), 32'(d), 32'(vecs[v].exp_data));
      check($sformatf("lb_err_v%0d", v), 32'(e), 32'(vecs[v].exp_err));
      step(40);
    end

    // Reset in the middle of a frame
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    wr_data = 8'h5A; wren = 1; step(1); wren = 0;
    wait_tx_low(400);
    step(40);
    #2 rstn = 0;
    #1;
    check("midreset_tx", 32'(tx), 32'h1);
    check("midreset_levels", 32'({tx_level, rx_level}), 32'h0);
    check("midreset_rd", 32'({rd_err, rd_data}), 32'h0);
    check("midreset_status", 32'(status), 32'h02);
    step(2);
    rstn = 1;
    step(800);
    check("midreset_no_push", 32'(rx_level), 32'h0);
    check("midreset_tx_idle", 32'(tx), 32'h1);

    // External rx, 8O1: parity error, framing error, clean
    loopback = 0;
    step(4);
    send_frame(2'd3, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 64);
    wait_level(1, 100); read_rx(d, e);
    check("ext_par_data", 32'(d), 32'h0F);
    check("ext_par_err", 32'(e), 32'h1);
    send_frame(2'd3, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 64);
    wait_level(1, 100); read_rx(d, e);
    check("ext_frm_data", 32'(d), 32'h81);
    check("ext_frm_err", 32'(e), 32'h2);
    send_frame(2'd3, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 64);
    wait_level(1, 100); read_rx(d, e);
    check("ext_clean_data", 32'(d), 32'h3C);
    check("ext_clean_err", 32'(e), 32'h0);

    // Start-bit glitch of 4 ticks is rejected, a real frame follows
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    rx = 0; step(16); rx = 1; step(128);
    check("glitch_level", 32'(rx_level), 32'h0);
    check("glitch_busy", 32'(status[4]), 32'h0);
    send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 64);
    wait_level(1, 100); read_rx(d, e);
    check("after_glitch_data", 32'(d), 32'h5A);

    // TX FIFO full: fifth write dropped
    loopback = 1; tx_en = 0; baud_div = 16'd0;
    step(8);
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h11 * (i + 1)); wren = 1; step(1);
    end
    wren = 0;
    check("tx_full_level", 32'(tx_level), 32'h4);
    check("tx_full_flag", 32'(status[0]), 32'h1);
    tx_en = 1;
    wait_level(4, 2000);
    check("tx_drain_level", 32'(tx_level), 32'h0);
    for (int i = 0; i < 4; i++) begin
      read_rx(d, e);
      check($sformatf("tx_fifo_order%0d", i), 32'(d), 32'(8'h11 * (i + 1)));
    end
    check("tx_fifo_no_ovr", 32'(status[5]), 32'h0);

    // RX overrun: six frames into a four-entry FIFO
    loopback = 0;
    step(8);
    for (int i = 0; i < 6; i++) send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'(8'hB0 + i), 1'b0, 1'b0, 16);
    check("ovr_level", 32'(rx_level), 32'h4);
    check("ovr_flag", 32'(status[5]), 32'h1);
    check("ovr_full", 32'(status[2]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      read_rx(d, e);
      check($sformatf("ovr_order%0d", i), 32'(d), 32'(8'hB0 + i));
    end
    check("ovr_still_set", 32'(status[5]), 32'h1);
    ovr_clr = 1; step(1); ovr_clr = 0;
    check("ovr_cleared", 32'(status[5]), 32'h0);
    read_rx(d, e);
    check("empty_read_holds", 32'(d), 32'hB3);

    // Randomised external frames against the reference model
    for (int r = 0; r < 10; r++) begin
      dv = $urandom_range(0, 2);
      baud_div = 16'(dv);
      bitclk = 16 * (dv + 1);
      step(6);
      len = 2'($urandom_range(0, 3)); pen = 1'($urandom); podd = 1'($urandom);
      s2 = 1'($urandom); b = 8'($urandom);
      flip = pen & 1'($urandom); zs = ($urandom_range(0, 3) == 0);
      w = expect_word(len, pen, b, flip, zs);
      send_frame(len, pen, podd, s2, b, flip, zs, bitclk);
      wait_level(1, 200);
      read_rx(d, e);
      check($sformatf("rand%0d_data", r), 32'(d), 32'(w[7:0]));
      check($sformatf("rand%0d_err", r), 32'(e), 32'(w[9:8]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
